// File: rtl/spmv_fp16_mul_pipe.sv
// ============================================================================
// Module  : spmv_fp16_mul_pipe
// Purpose : LANES-wide pipelined IEEE-754 binary16 multiplier for the SpMV
//           datapath, with valid/ready handshake and per-lane exception flags.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module spmv_fp16_mul_pipe #(
    parameter int LANES     = 1,
    parameter int ROUND_RNE = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [16*LANES-1:0]   i_vector,
    input  logic [16*LANES-1:0]   i_value,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [16*LANES-1:0]   o_result,
    output logic [4*LANES-1:0]    o_flags
);

    localparam logic [1:0] c_CLS_NORM = 2'd0;
    localparam logic [1:0] c_CLS_NAN  = 2'd1;
    localparam logic [1:0] c_CLS_INF  = 2'd2;
    localparam logic [1:0] c_CLS_ZERO = 2'd3;

    logic w_en;
    logic r_v1, r_v2, r_v3;

    // Single global stall: every stage moves only when the output slot frees.
    assign w_en    = ~r_v3 | i_ready;
    assign o_ready = w_en;
    assign o_valid = r_v3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_en) begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [15:0]        w_a, w_b;
        logic               w_a_zero, w_a_inf, w_a_nan;
        logic               w_b_zero, w_b_inf, w_b_nan;
        logic [1:0]         w_cls;
        logic signed [6:0]  w_exp_sum;

        logic               r1_sign;
        logic [1:0]         r1_cls;
        logic signed [6:0]  r1_exp;
        logic [9:0]         r1_ma, r1_mb;

        logic               r2_sign;
        logic [1:0]         r2_cls;
        logic signed [6:0]  r2_exp;
        logic [21:0]        r2_prod;

        logic               w_p21;
        logic [9:0]         w_mant_n;
        logic               w_guard, w_sticky, w_inc, w_inexact;
        logic [10:0]        w_mant_r;
        logic signed [6:0]  w_exp_n, w_exp_f;
        logic [15:0]        w_res;
        logic [3:0]         w_flg;

        logic [15:0]        r_res;
        logic [3:0]         r_flg;

        assign w_a = i_value[16*k +: 16];
        assign w_b = i_vector[16*k +: 16];

        // Subnormal inputs fall into the zero class (flush without flag).
        assign w_a_zero = (w_a[14:10] == 5'd0);
        assign w_a_inf  = (w_a[14:10] == 5'h1F) && (w_a[9:0] == 10'd0);
        assign w_a_nan  = (w_a[14:10] == 5'h1F) && (w_a[9:0] != 10'd0);
        assign w_b_zero = (w_b[14:10] == 5'd0);
        assign w_b_inf  = (w_b[14:10] == 5'h1F) && (w_b[9:0] == 10'd0);
        assign w_b_nan  = (w_b[14:10] == 5'h1F) && (w_b[9:0] != 10'd0);

        always_comb begin
            w_cls = c_CLS_NORM;
            if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
                w_cls = c_CLS_NAN;
            else if (w_a_inf || w_b_inf)
                w_cls = c_CLS_INF;
            else if (w_a_zero || w_b_zero)
                w_cls = c_CLS_ZERO;
        end

        assign w_exp_sum = $signed({2'b00, w_a[14:10]}) + $signed({2'b00, w_b[14:10]}) - 7'sd15;

        always_ff @(posedge i_clk) begin
            if (w_en) begin
                r1_sign <= w_a[15] ^ w_b[15];
                r1_cls  <= w_cls;
                r1_exp  <= w_exp_sum;
                r1_ma   <= w_a[9:0];
                r1_mb   <= w_b[9:0];

                r2_sign <= r1_sign;
                r2_cls  <= r1_cls;
                r2_exp  <= r1_exp;
                r2_prod <= 22'({1'b1, r1_ma}) * 22'({1'b1, r1_mb});
            end
        end

        assign w_p21     = r2_prod[21];
        assign w_mant_n  = w_p21 ? r2_prod[20:11] : r2_prod[19:10];
        assign w_guard   = w_p21 ? r2_prod[10] : r2_prod[9];
        assign w_sticky  = w_p21 ? (|r2_prod[9:0]) : (|r2_prod[8:0]);
        assign w_inc     = (ROUND_RNE != 0) && w_guard && (w_sticky || w_mant_n[0]);
        assign w_inexact = w_guard | w_sticky;
        assign w_mant_r  = {1'b0, w_mant_n} + {10'd0, w_inc};
        assign w_exp_n   = r2_exp + $signed({6'd0, w_p21});
        assign w_exp_f   = w_exp_n + $signed({6'd0, w_mant_r[10]});

        always_comb begin
            w_res = 16'h0000;
            w_flg = 4'b0000;
            case (r2_cls)
                c_CLS_NAN: begin
                    w_res = 16'h7E00;
                    w_flg = 4'b1000;
                end
                c_CLS_INF:  w_res = {r2_sign, 5'h1F, 10'h000};
                c_CLS_ZERO: w_res = {r2_sign, 15'h0000};
                default: begin
                    if (w_exp_f >= 7'sd31) begin
                        w_flg = 4'b0101;
                        w_res = (ROUND_RNE != 0) ? {r2_sign, 5'h1F, 10'h000}
                                                 : {r2_sign, 15'h7BFF};
                    end else if (w_exp_f <= 7'sd0) begin
                        w_flg = 4'b0011;
                        w_res = {r2_sign, 15'h0000};
                    end else begin
                        w_flg = {3'b000, w_inexact};
                        w_res = {r2_sign, w_exp_f[4:0], w_mant_r[9:0]};
                    end
                end
            endcase
        end

        // Output registers only load with a real beat so they hold during stalls.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_res <= 16'h0000;
                r_flg <= 4'b0000;
            end else if (w_en && r_v2) begin
                r_res <= w_res;
                r_flg <= w_flg;
            end
        end

        assign o_result[16*k +: 16] = r_res;
        assign o_flags[4*k +: 4]    = r_flg;
    end

endmodule

`default_nettype wire

// File: tb/tb_spmv_fp16_mul_pipe.sv
// ============================================================================
// Module  : tb_spmv_fp16_mul_pipe
// Purpose : Directed self-checking bench, RNE and truncate instances side by side.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spmv_fp16_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready_in;
    logic [63:0] vec, val;

    logic        rdy_r, ov_r, rdy_t, ov_t;
    logic [63:0] res_r, res_t;
    logic [15:0] flg_r, flg_t;

    int tests = 0;
    int fails = 0;
    int sent, got;
    logic in_fire, out_fire;

    always #5 clk = ~clk;

    spmv_fp16_mul_pipe #(.LANES(4), .ROUND_RNE(1)) u_rne (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy_r),
        .i_vector(vec), .i_value(val), .o_valid(ov_r), .i_ready(ready_in),
        .o_result(res_r), .o_flags(flg_r)
    );

    spmv_fp16_mul_pipe #(.LANES(4), .ROUND_RNE(0)) u_trn (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy_t),
        .i_vector(vec), .i_value(val), .o_valid(ov_t), .i_ready(ready_in),
        .o_result(res_t), .o_flags(flg_t)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Beat j of the stream: each lane is a distinct normal value times 1.0.
    function automatic logic [63:0] beat(input int j);
        logic [63:0] b;
        for (int k = 0; k < 4; k++)
            b[16*k +: 16] = 16'h4000 + 16'(j * 16 + k);
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; ready_in = 1'b1; vec = '0; val = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset_valid", 64'(ov_r), 64'd0);
        chk("reset_result", res_r, 64'd0);
        chk("reset_flags", 64'(flg_r), 64'd0);
        chk("reset_valid_trn", 64'(ov_t), 64'd0);
        chk("idle_ready", 64'(rdy_r), 64'd1);

        // Basic latency: 1*1 then 1.5*1.5
        val = {4{16'h3C00}}; vec = {4{16'h3C00}}; valid = 1'b1;
        cyc();
        val = {4{16'h3E00}}; vec = {4{16'h3E00}};
        cyc();
        valid = 1'b0;
        chk("lat_not_yet", 64'(ov_r), 64'd0);
        cyc();
        chk("lat_valid", 64'(ov_r), 64'd1);
        chk("lat_res0", res_r, {4{16'h3C00}});
        chk("lat_flg0", 64'(flg_r), 64'd0);
        cyc();
        chk("lat_valid1", 64'(ov_r), 64'd1);
        chk("lat_res1", res_r, {4{16'h4080}});
        chk("lat_flg1", 64'(flg_r), 64'd0);
        cyc();
        chk("lat_drain", 64'(ov_r), 64'd0);

        // Rounding, overflow, underflow; then signs/specials; then mixed
        val = {16'h0400, 16'h7BFF, 16'h3C01, 16'h3C01};
        vec = {16'h0400, 16'h4000, 16'h3C01, 16'h3E00};
        valid = 1'b1;
        cyc();
        val = {16'h7E55, 16'h7C00, 16'hC000, 16'h8000};
        vec = {16'h3C00, 16'h0000, 16'h3C00, 16'h3C00};
        cyc();
        val = {16'h7800, 16'hC000, 16'h0000, 16'hFC00};
        vec = {16'h7800, 16'h4000, 16'hFC00, 16'h3C00};
        cyc();
        valid = 1'b0;
        chk("round_res_rne", res_r, {16'h0000, 16'h7C00, 16'h3C02, 16'h3E02});
        chk("round_flg_rne", 64'(flg_r), 64'h3511);
        chk("round_res_trn", res_t, {16'h0000, 16'h7BFF, 16'h3C02, 16'h3E01});
        chk("round_flg_trn", 64'(flg_t), 64'h3511);
        cyc();
        chk("spec_res_rne", res_r, {16'h7E00, 16'h7E00, 16'hC000, 16'h8000});
        chk("spec_flg_rne", 64'(flg_r), 64'h8800);
        chk("spec_res_trn", res_t, {16'h7E00, 16'h7E00, 16'hC000, 16'h8000});
        chk("spec_flg_trn", 64'(flg_t), 64'h8800);
        cyc();
        chk("mix_res_rne", res_r, {16'h7C00, 16'hC400, 16'h7E00, 16'hFC00});
        chk("mix_flg_rne", 64'(flg_r), 64'h5080);
        chk("mix_res_trn", res_t, {16'h7BFF, 16'hC400, 16'h7E00, 16'hFC00});
        chk("mix_flg_trn", 64'(flg_t), 64'h5080);
        cyc(); cyc();
        chk("mix_drain", 64'(ov_r), 64'd0);

        // Backpressure: 6 beats, downstream stalls cycles 4..9
        sent = 0; got = 0;
        for (int c = 0; c < 30; c++) begin
            ready_in = !(c >= 4 && c <= 9);
            valid    = (sent < 6);
            val      = (sent < 6) ? beat(sent) : 64'd0;
            vec      = {4{16'h3C00}};
            @(negedge clk);
            if (ov_r) begin
                if (got < 6) begin
                    chk("bp_data", res_r, beat(got));
                    chk("bp_flags", 64'(flg_r), 64'd0);
                end else begin
                    chk("bp_extra_beat", 64'(ov_r), 64'd0);
                end
                if (c >= 4 && c <= 9)
                    chk("bp_ready_low", 64'(rdy_r), 64'd0);
            end
            in_fire  = valid & rdy_r;
            out_fire = ov_r & ready_in;
            @(posedge clk);
            #1;
            if (in_fire)  sent++;
            if (out_fire) got++;
        end
        valid = 1'b0; ready_in = 1'b1;
        chk("bp_sent", 64'(sent), 64'd6);
        chk("bp_got", 64'(got), 64'd6);

        // Reset with three beats in flight
        vec = {4{16'h3C00}};
        val = {4{16'h4100}}; valid = 1'b1;
        cyc();
        val = {4{16'h4200}};
        cyc();
        val = {4{16'h4300}}; rst = 1'b1;
        cyc();
        rst = 1'b0; valid = 1'b0;
        chk("rst_mid_valid", 64'(ov_r), 64'd0);
        chk("rst_mid_result", res_r, 64'd0);
        chk("rst_mid_flags", 64'(flg_r), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rst_no_ghost", 64'(ov_r), 64'd0);
        end
        val = {4{16'h4800}}; valid = 1'b1;
        chk("post_rst_ready", 64'(rdy_r), 64'd1);
        cyc();
        valid = 1'b0;
        cyc();
        chk("post_rst_lat", 64'(ov_r), 64'd0);
        cyc();
        chk("post_rst_valid", 64'(ov_r), 64'd1);
        chk("post_rst_res", res_r, {4{16'h4800}});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
